// File: rtl/flow_rate_meter_pkg.sv
// Shared types and helpers for flow_rate_meter: beat byte width, skid occupancy
// encoding and saturating counter addition.
package flow_rate_meter_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // Adds two values and clamps the result to the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid register slice: one cycle of latency, full throughput, registered
// ready that drops only while both entries hold a beat.
module axis_skid_buf #(
    parameter int C_PAYLOAD_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [C_PAYLOAD_WIDTH-1:0] s_payload,
    output logic                       s_ready,
    output logic                       m_valid,
    output logic [C_PAYLOAD_WIDTH-1:0] m_payload,
    input  logic                       m_ready
);
    import flow_rate_meter_pkg::*;

    skid_state_t                state;
    skid_state_t                state_next;
    logic [C_PAYLOAD_WIDTH-1:0] skid_payload;
    logic                       in_hs;
    logic                       out_hs;
    logic                       load_out_from_in;
    logic                       load_out_from_skid;
    logic                       load_skid;

    assign m_valid = (state != EMPTY);
    assign in_hs   = s_valid && s_ready;
    assign out_hs  = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (in_hs) state_next = ONE;
            ONE: begin
                if (in_hs && !out_hs)      state_next = TWO;
                else if (!in_hs && out_hs) state_next = EMPTY;
            end
            TWO:     if (out_hs) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // The output register always holds the oldest beat; the skid entry only fills
    // when a beat arrives while the output is stalled.
    always_comb begin
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        unique case (state)
            EMPTY: load_out_from_in = in_hs;
            ONE: begin
                load_out_from_in = in_hs && out_hs;
                load_skid        = in_hs && !out_hs;
            end
            TWO:     load_out_from_skid = out_hs;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready      <= 1'b0;
            m_payload    <= '0;
            skid_payload <= '0;
        end else begin
            s_ready <= (state_next != TWO);
            if (load_out_from_in)        m_payload <= s_payload;
            else if (load_out_from_skid) m_payload <= skid_payload;
            if (load_skid) skid_payload <= s_payload;
        end
    end

endmodule

// File: rtl/flow_rate_meter.sv
// AXI-Stream pass-through that measures bytes and packets per fixed window.
// Define FLOW_RATE_METER_MAXLEN_EN to also report the longest packet per window.
module flow_rate_meter #(
    parameter int C_DATA_WIDTH    = 64,
    parameter int C_MTY_WIDTH     = 3,
    parameter int C_CNT_WIDTH     = 32,
    parameter int C_WINDOW_CYCLES = 1000
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_axis_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [C_MTY_WIDTH-1:0]  s_axis_tuser_mty,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]  m_axis_tuser_mty,
    input  logic                    m_axis_tready,
    output logic [C_CNT_WIDTH-1:0]  rate_bytes,
    output logic [C_CNT_WIDTH-1:0]  rate_pkts,
    output logic                    rate_update,
    output logic [C_CNT_WIDTH-1:0]  max_pkt_bytes
);
    import flow_rate_meter_pkg::*;

    localparam int C_BEAT_BYTES    = beat_bytes(C_DATA_WIDTH);
    localparam int C_PAYLOAD_WIDTH = C_DATA_WIDTH + 1 + C_MTY_WIDTH;
    localparam int C_WIN_WIDTH     = (C_WINDOW_CYCLES > 1) ? $clog2(C_WINDOW_CYCLES) : 1;
    localparam logic [C_WIN_WIDTH-1:0] C_WIN_LAST = C_WIN_WIDTH'(C_WINDOW_CYCLES - 1);

    logic [C_PAYLOAD_WIDTH-1:0] m_payload;
    logic                       beat_hs;
    logic                       last_hs;
    logic                       win_wrap;
    logic [C_WIN_WIDTH-1:0]     win_cnt;
    logic [C_CNT_WIDTH-1:0]     acc_bytes;
    logic [C_CNT_WIDTH-1:0]     acc_pkts;
    logic [C_CNT_WIDTH-1:0]     bytes_sum;
    logic [C_CNT_WIDTH-1:0]     pkts_sum;
    logic [63:0]                beat_add;

    axis_skid_buf #(
        .C_PAYLOAD_WIDTH(C_PAYLOAD_WIDTH)
    ) u_skid (
        .clk      (aclk),
        .rst      (areset),
        .s_valid  (s_axis_tvalid),
        .s_payload({s_axis_tdata, s_axis_tlast, s_axis_tuser_mty}),
        .s_ready  (s_axis_tready),
        .m_valid  (m_axis_tvalid),
        .m_payload(m_payload),
        .m_ready  (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty} = m_payload;

    assign beat_hs  = m_axis_tvalid && m_axis_tready;
    assign last_hs  = beat_hs && m_axis_tlast;
    assign win_wrap = (win_cnt == C_WIN_LAST);

    // An over-range empty count on a last beat still carries one real byte.
    always_comb begin
        beat_add = '0;
        if (beat_hs) begin
            if (!m_axis_tlast)
                beat_add = 64'(C_BEAT_BYTES);
            else if (64'(m_axis_tuser_mty) >= 64'(C_BEAT_BYTES))
                beat_add = 64'd1;
            else
                beat_add = 64'(C_BEAT_BYTES) - 64'(m_axis_tuser_mty);
        end
    end

    assign bytes_sum = C_CNT_WIDTH'(sat_add(64'(acc_bytes), beat_add, C_CNT_WIDTH));
    assign pkts_sum  = C_CNT_WIDTH'(sat_add(64'(acc_pkts), 64'(last_hs), C_CNT_WIDTH));

    // The wrap cycle's beat closes into the reported totals, so the accumulators restart at zero.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            win_cnt     <= '0;
            acc_bytes   <= '0;
            acc_pkts    <= '0;
            rate_bytes  <= '0;
            rate_pkts   <= '0;
            rate_update <= 1'b0;
        end else begin
            rate_update <= win_wrap;
            if (win_wrap) begin
                win_cnt    <= '0;
                acc_bytes  <= '0;
                acc_pkts   <= '0;
                rate_bytes <= bytes_sum;
                rate_pkts  <= pkts_sum;
            end else begin
                win_cnt   <= win_cnt + 1'b1;
                acc_bytes <= bytes_sum;
                acc_pkts  <= pkts_sum;
            end
        end
    end

`ifdef FLOW_RATE_METER_MAXLEN_EN
    logic [C_CNT_WIDTH-1:0] pkt_bytes;
    logic [C_CNT_WIDTH-1:0] pkt_len;
    logic [C_CNT_WIDTH-1:0] win_max;
    logic [C_CNT_WIDTH-1:0] win_max_next;
    logic [C_CNT_WIDTH-1:0] max_reg;

    assign pkt_len      = C_CNT_WIDTH'(sat_add(64'(pkt_bytes), beat_add, C_CNT_WIDTH));
    assign win_max_next = (last_hs && (pkt_len > win_max)) ? pkt_len : win_max;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_bytes <= '0;
            win_max   <= '0;
            max_reg   <= '0;
        end else begin
            pkt_bytes <= last_hs ? '0 : pkt_len;
            if (win_wrap) begin
                max_reg <= win_max_next;
                win_max <= '0;
            end else begin
                win_max <= win_max_next;
            end
        end
    end

    assign max_pkt_bytes = max_reg;
`else
    assign max_pkt_bytes = '0;
`endif

endmodule

// File: tb/tb_flow_rate_meter.sv
// Directed bench for flow_rate_meter: a default-width instance plus an 8-bit-counter
// instance with a short window, both fed by the same stream.
`timescale 1ns/1ps
module tb_flow_rate_meter;

    localparam int DW      = 64;
    localparam int MW      = 3;
    localparam int CW      = 32;
    localparam int WIN     = 1000;
    localparam int SAT_CW  = 8;
    localparam int SAT_WIN = 50;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [MW-1:0] mty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [MW-1:0] s_mty;
    logic          m_ready;

    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [MW-1:0] m_mty;
    logic [CW-1:0] rate_bytes;
    logic [CW-1:0] rate_pkts;
    logic          rate_update;
    logic [CW-1:0] max_bytes;

    logic              sat_s_ready;
    logic              sat_m_valid;
    logic [DW-1:0]     sat_m_data;
    logic              sat_m_last;
    logic [MW-1:0]     sat_m_mty;
    logic [SAT_CW-1:0] sat_rate_bytes;
    logic [SAT_CW-1:0] sat_rate_pkts;
    logic              sat_rate_update;
    logic [SAT_CW-1:0] sat_max_bytes;

    int    check_count = 0;
    int    fail_count  = 0;
    int    edge_n;
    int    n_in        = 0;
    int    n_out       = 0;
    bit    chk_ready   = 1'b0;
    bit    ready_drop  = 1'b0;
    bit    stream_done = 1'b0;
    beat_t exp_q[$];
    beat_t exp_beat;

    initial forever #5 clk = ~clk;

    flow_rate_meter #(
        .C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW), .C_CNT_WIDTH(CW), .C_WINDOW_CYCLES(WIN)
    ) dut (
        .aclk(clk), .areset(rst),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .s_axis_tuser_mty(s_mty), .s_axis_tready(s_ready),
        .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tlast(m_last),
        .m_axis_tuser_mty(m_mty), .m_axis_tready(m_ready),
        .rate_bytes(rate_bytes), .rate_pkts(rate_pkts), .rate_update(rate_update),
        .max_pkt_bytes(max_bytes)
    );

    flow_rate_meter #(
        .C_DATA_WIDTH(DW), .C_MTY_WIDTH(MW), .C_CNT_WIDTH(SAT_CW), .C_WINDOW_CYCLES(SAT_WIN)
    ) dut_sat (
        .aclk(clk), .areset(rst),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .s_axis_tuser_mty(s_mty), .s_axis_tready(sat_s_ready),
        .m_axis_tvalid(sat_m_valid), .m_axis_tdata(sat_m_data), .m_axis_tlast(sat_m_last),
        .m_axis_tuser_mty(sat_m_mty), .m_axis_tready(m_ready),
        .rate_bytes(sat_rate_bytes), .rate_pkts(sat_rate_pkts), .rate_update(sat_rate_update),
        .max_pkt_bytes(sat_max_bytes)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] expMax(input logic [63:0] len);
`ifdef FLOW_RATE_METER_MAXLEN_EN
        return len;
`else
        return 64'd0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    // Handshakes seen at a falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_in  = 0;
            n_out = 0;
        end else begin
            if (chk_ready) begin
                checkOutput("ready_vs_occupancy", s_ready, ((n_in - n_out) != 2) ? 1 : 0);
                if (!s_ready) ready_drop = 1'b1;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stream_extra_beat", 1, 0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("stream_data", m_data, exp_beat.data);
                    checkOutput("stream_last_mty", {m_last, m_mty}, {exp_beat.last, exp_beat.mty});
                end
                n_out++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back('{data: s_data, last: s_last, mty: s_mty});
                n_in++;
            end
        end
    end

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_mty   = '0;
    endtask

    task automatic applyStimulus(input logic last, input logic [MW-1:0] mty);
        logic accepted;
        accepted = 1'b0;
        s_valid  = 1'b1;
        s_data   = {$urandom, $urandom};
        s_last   = last;
        s_mty    = mty;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            accepted = s_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitUpdate(input bit sat, output int at_edge);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge clk);
            seen = sat ? sat_rate_update : rate_update;
        end
        at_edge = edge_n;
        if (!seen) checkOutput(sat ? "sat_update_timeout" : "update_timeout", 0, 1);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitEdge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t1, t2, t3, ts;
        idle();
        s_data  = '0;
        m_ready = 1'b1;

        #23;
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_m_last_mty", {m_last, m_mty}, 0);
        checkOutput("rst_rate_bytes", rate_bytes, 0);
        checkOutput("rst_rate_pkts", rate_pkts, 0);
        checkOutput("rst_rate_update", rate_update, 0);
        checkOutput("rst_max_bytes", max_bytes, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", s_ready, 1);

        // 3-beat packet, 5 empty bytes on the last beat: 8 + 8 + 3 = 19 bytes
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b1, 3'd5);
        idle();
        waitUpdate(1'b0, t1);
        checkOutput("short_pkt_bytes", rate_bytes, 19);
        checkOutput("short_pkt_pkts", rate_pkts, 1);
        checkOutput("short_pkt_max", max_bytes, expMax(19));
        repeat (20) @(negedge clk);
        checkOutput("hold_rate_bytes", rate_bytes, 19);
        checkOutput("hold_rate_update", rate_update, 0);

        // Asynchronous reset with two beats parked in the skid and a partial packet counted
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        m_ready = 1'b0;
        applyStimulus(1'b0, 3'd0);
        idle();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midrst_m_valid", m_valid, 0);
        checkOutput("midrst_s_ready", s_ready, 0);
        checkOutput("midrst_m_data", m_data, 0);
        checkOutput("midrst_rate_bytes", rate_bytes, 0);
        checkOutput("midrst_rate_pkts", rate_pkts, 0);
        #2 rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready_back", s_ready, 1);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b1, 3'd0);
        idle();
        waitUpdate(1'b0, t1);
        checkOutput("post_rst_bytes", rate_bytes, 16);
        checkOutput("post_rst_pkts", rate_pkts, 1);
        checkOutput("post_rst_max", max_bytes, expMax(16));

        // Output ready toggling every cycle under a continuous input stream
        resetDut();
        chk_ready   = 1'b1;
        ready_drop  = 1'b0;
        stream_done = 1'b0;
        fork
            begin
                for (int b = 1; b <= 40; b++) applyStimulus((b % 8) == 0, 3'd0);
                idle();
                stream_done = 1'b1;
            end
            begin
                for (int i = 0; i < 1000 && !stream_done; i++) begin
                    @(posedge clk);
                    #1;
                    m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk_ready = 1'b0;
        checkOutput("toggle_drained", exp_q.size(), 0);
        checkOutput("toggle_beats_out", n_out, 40);
        checkOutput("toggle_ready_dropped", ready_drop, 1);

        // Last beat of a 3-beat packet handshakes on the wrap edge (E1000)
        resetDut();
        waitEdge(WIN - 4);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b1, 3'd0);
        idle();
        waitUpdate(1'b0, t1);
        checkOutput("wrap_edge", t1, WIN);
        checkOutput("wrap_close_bytes", rate_bytes, 24);
        checkOutput("wrap_close_pkts", rate_pkts, 1);
        checkOutput("wrap_close_max", max_bytes, expMax(24));
        waitUpdate(1'b0, t2);
        checkOutput("wrap_next_bytes", rate_bytes, 0);
        checkOutput("wrap_next_pkts", rate_pkts, 0);
        checkOutput("wrap_next_max", max_bytes, 0);

        // Continuous 64-byte packets; window 1 loses the first two fill cycles
        resetDut();
        fork
            begin
                for (int b = 1; b <= 3100; b++) applyStimulus((b % 8) == 0, 3'd0);
                idle();
            end
            begin
                waitUpdate(1'b0, t1);
                checkOutput("steady_w1_bytes", rate_bytes, 7984);
                checkOutput("steady_w1_pkts", rate_pkts, 124);
                waitUpdate(1'b0, t2);
                checkOutput("steady_w2_bytes", rate_bytes, 8000);
                checkOutput("steady_w2_pkts", rate_pkts, 125);
                checkOutput("steady_w2_max", max_bytes, expMax(64));
                checkOutput("steady_period_a", t2 - t1, WIN);
                waitUpdate(1'b0, t3);
                checkOutput("steady_w3_bytes", rate_bytes, 8000);
                checkOutput("steady_w3_pkts", rate_pkts, 125);
                checkOutput("steady_period_b", t3 - t2, WIN);
            end
            begin
                waitUpdate(1'b1, ts);
                checkOutput("sat_w1_bytes", sat_rate_bytes, 255);
                checkOutput("sat_w1_pkts", sat_rate_pkts, 6);
                waitUpdate(1'b1, ts);
                checkOutput("sat_w2_bytes", sat_rate_bytes, 255);
                checkOutput("sat_w2_pkts", sat_rate_pkts, 6);
            end
        join
        repeat (5) @(negedge clk);
        checkOutput("steady_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

    initial begin
        #2_000_000;
        fail_count++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
